// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for a stallable load/store port.
//   One request is accepted at a time over a valid/ready handshake. The
//   access happens WAIT_CYCLES edges after acceptance. The access is
//   little-endian byte/half/word with RISC-V funct3 semantics. Read data
//   and an error flag return over a second valid/ready handshake.
//
// Parameters
//   DEPTH_WORDS  storage size in 32-bit words (byte addresses 0..4*DEPTH_WORDS-1)
//   WAIT_CYCLES  wait states between acceptance and access (0 allowed)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                          rejected with rsp_err. When undefined, the low
//                          address bits are ignored, which force-aligns
//                          the access.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   request present
//   req_ready   responder can accept (IDLE and reset low)
//   req_write   1 = store, 0 = load
//   req_funct3  000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   response present
//   rsp_ready   requester takes the response
//   rsp_rdata   load result; 0 for stores and errors
//   rsp_err     request rejected; storage unchanged
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [32:0] BYTE_LIMIT = 33'(longint'(DEPTH_WORDS) * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_write;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_access;
  logic              w_a_write;
  logic [2:0]        w_a_f3;
  logic [31:0]       w_a_addr;
  logic [31:0]       w_a_wdata;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic              w_mem_we;

  assign w_accept = req_valid & req_ready;

  // With zero wait states the access happens on the accepting edge itself,
  // so it must use the live request rather than the latched copy.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      w_a_write = req_write;
      w_a_f3    = req_funct3;
      w_a_addr  = req_addr;
      w_a_wdata = req_wdata;
      w_access  = w_accept;
    end else begin
      w_a_write = r_write;
      w_a_f3    = r_funct3;
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
      w_access  = (r_state == S_WAIT) && (r_cnt == '0);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (r_state == S_IDLE) && !reset;
    rsp_valid = (r_state == S_RESP);
  end

  // Wait-state counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_cnt <= '0;
    else if (w_accept)                              r_cnt <= CNT_INIT;
    else if ((r_state == S_WAIT) && (r_cnt != '0))  r_cnt <= r_cnt - 1'b1;
  end

  // Request capture; data path only, not reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Request legality
  always_comb begin
    w_err = 1'b0;
    if ({1'b0, w_a_addr} >= BYTE_LIMIT) w_err = 1'b1;
    case (w_a_f3)
      3'b011, 3'b110, 3'b111: w_err = 1'b1;
      3'b100, 3'b101:         if (w_a_write) w_err = 1'b1;
      default: ;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    case (w_a_f3)
      3'b001, 3'b101: if (w_a_addr[0]) w_err = 1'b1;
      3'b010:         if (w_a_addr[1:0] != 2'b00) w_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign w_idx  = w_a_addr[IDX_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_a_addr[1:0] +: 8];
  assign w_half = w_word[16*w_a_addr[1] +: 16];

  // Load extraction; half uses addr[1] only, word ignores addr[1:0]
  always_comb begin
    case (w_a_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // Store lane steering; data is replicated so each enabled byte picks its lane
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_a_wdata;
    case (w_a_f3)
      3'b000: begin
        w_be     = 4'b0001 << w_a_addr[1:0];
        w_wlanes = {4{w_a_wdata[7:0]}};
      end
      3'b001: begin
        w_be     = w_a_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_a_wdata[15:0]}};
      end
      3'b010: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_mem_we = w_access & w_a_write & ~w_err;

  // Storage; deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  // Response registers, loaded once per transaction and held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (w_access) begin
      rsp_err   <= w_err;
      rsp_rdata <= (w_err || w_a_write) ? 32'd0 : w_load;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total;
  int bad;

  logic [31:0] rd;
  logic        er;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction with rsp_ready held high; returns the response.
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] r, output logic e);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rsp_timeout", {31'd0, n >= 20}, 32'd0);
    r = rsp_rdata;
    e = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // SW DEADBEEF @0x10
    txn(1'b1, F_W, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw_err", {31'd0, er}, 32'd0);
    chk("sw_rdata", rd, 32'd0);

    // LW @0x10 with cycle-exact latency check
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F_W; req_addr = 32'h10; rsp_ready = 1'b1;
    @(posedge clk); #1;                       // E0
    req_valid = 1'b0;
    chk("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_e0_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;                       // E0+1
    chk("lat_e1_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;                       // E0+2 access
    chk("lat_e2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lw10_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("lw10_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;                       // handshake
    chk("lat_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_hs_ready", {31'd0, req_ready}, 32'd1);

    // Sub-word loads
    txn(1'b0, F_B,  32'h13, 32'd0, rd, er); chk("lb13",  rd, 32'hFFFFFFDE);
    txn(1'b0, F_BU, 32'h13, 32'd0, rd, er); chk("lbu13", rd, 32'h000000DE);
    txn(1'b0, F_H,  32'h12, 32'd0, rd, er); chk("lh12",  rd, 32'hFFFFDEAD);
    txn(1'b0, F_HU, 32'h12, 32'd0, rd, er); chk("lhu12", rd, 32'h0000DEAD);
    txn(1'b0, F_B,  32'h10, 32'd0, rd, er); chk("lb10",  rd, 32'hFFFFFFEF);
    txn(1'b0, F_BU, 32'h11, 32'd0, rd, er); chk("lbu11", rd, 32'h000000BE);
    txn(1'b0, F_HU, 32'h10, 32'd0, rd, er); chk("lhu10", rd, 32'h0000BEEF);

    // Sub-word stores
    txn(1'b1, F_B, 32'h11, 32'h000000AA, rd, er); chk("sb11_err", {31'd0, er}, 32'd0);
    txn(1'b0, F_W, 32'h10, 32'd0, rd, er);        chk("lw_after_sb", rd, 32'hDEADAAEF);
    txn(1'b1, F_H, 32'h12, 32'h00001234, rd, er); chk("sh12_err", {31'd0, er}, 32'd0);
    txn(1'b0, F_W, 32'h10, 32'd0, rd, er);        chk("lw_after_sh", rd, 32'h1234AAEF);

    // Backpressure: hold rsp_ready low for 5 cycles
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F_W; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h1234AAEF);
      chk("bp_err",   {31'd0, rsp_err}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_after_ready", {31'd0, req_ready}, 32'd1);

    // Misaligned word load
    txn(1'b0, F_W, 32'h12, 32'd0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw12_err", {31'd0, er}, 32'd1);
    chk("lw12_rdata", rd, 32'd0);
`else
    chk("lw12_err", {31'd0, er}, 32'd0);
    chk("lw12_rdata", rd, 32'h1234AAEF);
`endif

    // Out-of-range store must not alias onto word 0
    txn(1'b1, F_W, 32'h0, 32'hCAFEF00D, rd, er);
    txn(1'b1, F_W, 32'h401, 32'hFFFFFFFF, rd, er);
    chk("sw401_err", {31'd0, er}, 32'd1);
    chk("sw401_rdata", rd, 32'd0);
    txn(1'b1, F_W, 32'h400, 32'hFFFFFFFF, rd, er);
    chk("sw400_err", {31'd0, er}, 32'd1);
    txn(1'b0, F_W, 32'h0, 32'd0, rd, er);
    chk("w0_unchanged", rd, 32'hCAFEF00D);
    txn(1'b0, F_W, 32'h3FC, 32'd0, rd, er);
    chk("lw3fc_err", {31'd0, er}, 32'd0);

    // Store with unsigned funct3 is illegal
    txn(1'b1, F_BU, 32'h0, 32'h00000011, rd, er);
    chk("sbu_err", {31'd0, er}, 32'd1);
    txn(1'b0, F_W, 32'h0, 32'd0, rd, er);
    chk("w0_after_sbu", rd, 32'hCAFEF00D);

    // Reset during WAIT drops a store
    txn(1'b1, F_W, 32'h20, 32'h00000000, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h20;
    req_wdata = 32'h12345678; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rstmid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rstmid_after_valid", {31'd0, rsp_valid}, 32'd0);
    txn(1'b0, F_W, 32'h20, 32'd0, rd, er);
    chk("lw20_dropped", rd, 32'h00000000);
    chk("lw20_err", {31'd0, er}, 32'd0);

    // Reserved funct3
    txn(1'b0, F_BAD, 32'h10, 32'd0, rd, er);
    chk("f011_err", {31'd0, er}, 32'd1);
    chk("f011_rdata", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory end of the processor's load/store port. Accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles, performs a little-endian byte/half/word access with RISC-V funct3 semantics, and returns read data and an error flag over a second valid/ready handshake. It replaces the single-cycle data memory when the core moves to a stallable memory interface.

## Interface
- DEPTH_WORDS, 256: storage size in 32-bit words; valid byte addresses are 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states between request acceptance and access; 0 is legal.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE and reset deasserted.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected; no storage change.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/funct3/addr/wdata. Go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: counter decrements each cycle. On the edge where counter==0, perform the access, register rdata/err, go to RESP.
- RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable. On rsp_valid&rsp_ready, return to IDLE. Requests are ignored in WAIT/RESP.
- Loads: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
- Stores: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to lane addr[1]; SW writes all four bytes. Other bytes are untouched.
- Word index = addr[31:2].
- Errors set rsp_err=1, force rsp_rdata=0 and suppress any write:
  - addr ≥ 4*DEPTH_WORDS;
  - funct3 ∈ {011,110,111};
  - store with funct3 100/101;
  - misalignment (see Configuration).
- Storage contents are not affected by reset.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready=0 while reset is high.
- Latency: with E0 = accepting edge, the access occurs at edge E0+WAIT_CYCLES and rsp_valid is high from the following cycle.
- Minimum transaction period: WAIT_CYCLES+2 cycles. req_ready rises the cycle after the rsp handshake edge; there is no same-cycle re-accept.
- Backpressure: rsp_valid/rdata/err stay constant for any number of rsp_ready-low cycles.
- Reset mid-transaction (WAIT or RESP): transaction is dropped. A store still in WAIT is never committed. A store already in RESP has committed.
- Load after store to the same word sees the new data, since accesses are strictly serialized.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: these requests get rsp_err=1, no write, rdata=0:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠00.
- Undefined: low address bits below access size are ignored, so the access is force-aligned (half uses addr[1], word ignores addr[1:0]). No error is raised for misalignment.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF @0x10, then LW @0x10 → rdata 0xDEADBEEF, err 0, rsp_valid first high the cycle after E0+2.
- After that store: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x12 → 0x0000DEAD; LB @0x10 → 0xFFFFFFEF.
- SB 0x000000AA @0x11, then LW @0x10 → 0xDEADAAEF. SH 0x1234 @0x12, then LW @0x10 → 0x1234AAEF.
- Hold rsp_ready=0 for 5 cycles on a LW response → rsp_valid, rdata and err stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- LW @0x12 and SW @0x401 (DEPTH_WORDS=256):
  - with DMEM_MISALIGN_TRAP_EN, LW @0x12 → err 1, rdata 0;
  - without it, LW @0x12 returns the word @0x10;
  - in both builds, SW @0x401 → err 1 and memory unchanged.
- SW 0x12345678 @0x20 (prior value 0), reset pulsed during WAIT → rsp_valid=0 immediately; a following LW @0x20 returns 0x00000000. Funct3 011 load → err 1.
